// File: rtl/sprite_scene_renderer.sv
// Sprite scene renderer: NUM_SPRITES outlined rectangles over a background on the 96x64 OLED stream.
// Optional build macro SPRITE_BLINK_EN blanks the fill of the last-moved sprite 16 frames out of every 32.
module sprite_scene_renderer #(
   parameter int          NUM_SPRITES    = 2,
   parameter int          SPR_W          = 28,
   parameter int          SPR_H          = 12,
   parameter int          STEP           = 2,
   parameter int          INIT_X         = 30,
   parameter int          INIT_Y         = 11,
   parameter logic [15:0] OUTLINE_COLOUR = 16'h0000,
   parameter logic [15:0] FILL_COLOUR    = 16'h8204,
   parameter logic [15:0] BG_COLOUR      = 16'h5FFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [6:0]  x,
   input  logic [5:0]  y,
   input  logic        move_valid,
   input  logic [1:0]  move_id,
   input  logic [1:0]  move_dir,
   output logic        move_ready,
   output logic [15:0] oled_data
);

   localparam int SCREEN_W = 96;
   localparam int SCREEN_H = 64;

   localparam logic [7:0] MAX_X = 8'(SCREEN_W - SPR_W);
   localparam logic [7:0] MAX_Y = 8'(SCREEN_H - SPR_H);
   localparam logic [7:0] STEP8 = 8'(STEP);
   localparam logic [7:0] W8    = 8'(SPR_W);
   localparam logic [7:0] H8    = 8'(SPR_H);
   localparam logic [5:0] INIT_Y_C =
      6'((INIT_Y > SCREEN_H - SPR_H) ? (SCREEN_H - SPR_H) : INIT_Y);

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   function automatic logic [6:0] init_x(input int idx);
      int v;
      v = INIT_X + idx * (SPR_W + 2);
      if (v > SCREEN_W - SPR_W) v = SCREEN_W - SPR_W;
      return 7'(v);
   endfunction

   function automatic logic [7:0] sat_sub(input logic [7:0] v);
      return (v < STEP8) ? 8'd0 : (v - STEP8);
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [7:0] lim);
      return ((v + STEP8) > lim) ? lim : (v + STEP8);
   endfunction

   logic       pending;
   logic [1:0] p_id;
   logic [1:0] p_dir;
   logic       accept;
   logic       commit;

   logic [6:0] pos_x [NUM_SPRITES];
   logic [5:0] pos_y [NUM_SPRITES];
   logic [6:0] nxt_x [NUM_SPRITES];
   logic [5:0] nxt_y [NUM_SPRITES];

   assign move_ready = ~pending;
   assign accept     = move_valid && ~pending;
   assign commit     = frame_tick && pending;

   // An out-of-range p_id matches no sprite, so the command simply evaporates at commit.
   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         nxt_x[i] = pos_x[i];
         nxt_y[i] = pos_y[i];
         if (commit && (p_id == 2'(i))) begin
            case (p_dir)
               DIR_UP:    nxt_y[i] = 6'(sat_sub({2'b00, pos_y[i]}));
               DIR_DOWN:  nxt_y[i] = 6'(sat_add({2'b00, pos_y[i]}, MAX_Y));
               DIR_LEFT:  nxt_x[i] = 7'(sat_sub({1'b0, pos_x[i]}));
               DIR_RIGHT: nxt_x[i] = 7'(sat_add({1'b0, pos_x[i]}, MAX_X));
               default:   nxt_x[i] = pos_x[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= 1'b0;
         p_id    <= 2'd0;
         p_dir   <= 2'd0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x[i] <= init_x(i);
            pos_y[i] <= INIT_Y_C;
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x[i] <= nxt_x[i];
            pos_y[i] <= nxt_y[i];
         end
         if (accept) begin
            pending <= 1'b1;
            p_id    <= move_id;
            p_dir   <= move_dir;
         end else if (commit) begin
            pending <= 1'b0;
         end
      end
   end

`ifdef SPRITE_BLINK_EN
   logic [4:0] frame_cnt;
   logic [1:0] sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= 5'd0;
         sel       <= 2'd0;
      end else begin
         if (frame_tick) frame_cnt <= frame_cnt + 5'd1;
         if (commit)     sel       <= p_id;
      end
   end
`endif

   logic [7:0]             x8;
   logic [7:0]             y8;
   logic [NUM_SPRITES-1:0] spr_in;
   logic [NUM_SPRITES-1:0] spr_rim;

   assign x8 = {1'b0, x};
   assign y8 = {2'b00, y};

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
      logic [7:0] px;
      logic [7:0] py;
      assign px = {1'b0, pos_x[g]};
      assign py = {2'b00, pos_y[g]};
      assign spr_in[g]  = (x8 >= px) && (x8 < px + W8) && (y8 >= py) && (y8 < py + H8);
      assign spr_rim[g] = (x8 < px + 8'd2) || (x8 >= px + W8 - 8'd2) ||
                          (y8 < py + 8'd2) || (y8 >= py + H8 - 8'd2);
   end

   logic [15:0] pix;

   // Walk from the highest index down so the lowest-index sprite is written last and wins.
   always_comb begin
      pix = BG_COLOUR;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (spr_in[i]) begin
            if (spr_rim[i]) begin
               pix = OUTLINE_COLOUR;
            end else begin
               pix = FILL_COLOUR;
`ifdef SPRITE_BLINK_EN
               if (frame_cnt[4] && (sel == 2'(i))) pix = BG_COLOUR;
`endif
            end
         end
      end
      if (x8 >= 8'(SCREEN_W)) pix = BG_COLOUR;
   end

   always_ff @(posedge clk) begin
      if (reset) oled_data <= BG_COLOUR;
      else       oled_data <= pix;
   end

endmodule

// File: tb/tb_sprite_scene_renderer.sv
// Bench for sprite_scene_renderer: directed scenarios with literal pixel expectations plus
// randomized traffic, all checked every cycle against a frame-level behavioural model.
module tb_sprite_scene_renderer;

   localparam int          N      = 2;
   localparam int          W      = 28;
   localparam int          H      = 12;
   localparam int          STEP   = 2;
   localparam logic [15:0] C_OUT  = 16'h0000;
   localparam logic [15:0] C_FILL = 16'h8204;
   localparam logic [15:0] C_BG   = 16'h5FFF;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        frame_tick = 1'b0;
   logic [6:0]  x          = 7'd0;
   logic [5:0]  y          = 6'd0;
   logic        move_valid = 1'b0;
   logic [1:0]  move_id    = 2'd0;
   logic [1:0]  move_dir   = 2'd0;
   logic        move_ready;
   logic [15:0] oled_data;

   int checks = 0;
   int errors = 0;

   sprite_scene_renderer dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .x          (x),
      .y          (y),
      .move_valid (move_valid),
      .move_id    (move_id),
      .move_dir   (move_dir),
      .move_ready (move_ready),
      .oled_data  (oled_data)
   );

   always #5 clk = ~clk;

   // Behavioural model: sprite positions as plain integers, a one-slot command mailbox.
   int          mx [N];
   int          my [N];
   bit          m_pend   = 1'b0;
   int          m_id     = 0;
   int          m_dir    = 0;
   int          m_fcnt   = 0;
   int          m_sel    = 0;
   logic [15:0] exp_pix  = C_BG;
   bit          exp_ready = 1'b1;
   bit          model_ok = 1'b0;

   function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
   function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

   function automatic logic [15:0] model_pix(int xx, int yy);
      int dx, dy;
      if (xx >= 96 || yy >= 64) return C_BG;
      for (int i = 0; i < N; i++) begin
         dx = xx - mx[i];
         dy = yy - my[i];
         if (dx >= 0 && dx < W && dy >= 0 && dy < H) begin
            if (dx < 2 || dx >= W - 2 || dy < 2 || dy >= H - 2) return C_OUT;
`ifdef SPRITE_BLINK_EN
            if (m_fcnt >= 16 && i == m_sel) return C_BG;
`endif
            return C_FILL;
         end
      end
      return C_BG;
   endfunction

   initial forever begin
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            mx[i] = imin(30 + i * (W + 2), 96 - W);
            my[i] = imin(11, 64 - H);
         end
         m_pend   = 1'b0;
         m_fcnt   = 0;
         m_sel    = 0;
         exp_pix  = C_BG;
         model_ok = 1'b1;
      end else if (model_ok) begin
         exp_pix = model_pix(int'(x), int'(y));
         if (frame_tick && m_pend) begin
            if (m_id < N) begin
               case (m_dir)
                  0: my[m_id] = imax(my[m_id] - STEP, 0);
                  1: my[m_id] = imin(my[m_id] + STEP, 64 - H);
                  2: mx[m_id] = imax(mx[m_id] - STEP, 0);
                  default: mx[m_id] = imin(mx[m_id] + STEP, 96 - W);
               endcase
            end
            m_sel  = m_id;
            m_pend = 1'b0;
         end else if (move_valid && !m_pend) begin
            m_pend = 1'b1;
            m_id   = int'(move_id);
            m_dir  = int'(move_dir);
         end
         if (frame_tick) m_fcnt = (m_fcnt + 1) % 32;
      end
      exp_ready = !m_pend;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_ok) begin
         chk("model_oled_data", 32'(oled_data), 32'(exp_pix));
         chk("model_move_ready", 32'(move_ready), 32'(exp_ready));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string name, input int px, input int py, input logic [15:0] expv);
      x = 7'(px);
      y = 6'(py);
      step();
      chk(name, 32'(oled_data), 32'(expv));
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic send_move(input int id, input int dir);
      int n;
      n = 0;
      while (!move_ready && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         errors++;
         checks++;
         $display("FAIL move_ready_timeout: got 0 expected 1 within 100 cycles");
      end
      move_valid = 1'b1;
      move_id    = 2'(id);
      move_dir   = 2'(dir);
      step();
      move_valid = 1'b0;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();

      chk("reset_move_ready", 32'(move_ready), 32'd1);
      probe("reset_outline_30_11", 30, 11, C_OUT);
      probe("reset_fill_32_13", 32, 13, C_FILL);
      probe("reset_bg_0_0", 0, 0, C_BG);
      probe("reset_bg_95_63", 95, 63, C_BG);
      probe("offscreen_x100", 100, 15, C_BG);
      probe("reset_sprite1_outline_60_11", 60, 11, C_OUT);

      send_move(0, 3);
      chk("handshake_ready_low", 32'(move_ready), 32'd0);
      move_valid = 1'b1;
      move_id    = 2'd1;
      move_dir   = 2'd2;
      repeat (3) begin
         step();
         chk("handshake_held_off", 32'(move_ready), 32'd0);
      end
      move_valid = 1'b0;
      tick();
      chk("handshake_ready_after_commit", 32'(move_ready), 32'd1);
      probe("moved_right_old_corner_bg", 30, 11, C_BG);
      probe("moved_right_new_corner", 32, 11, C_OUT);
      probe("sprite1_not_moved", 60, 11, C_OUT);

      repeat (20) begin
         send_move(0, 2);
         tick();
      end
      chk("model_pin_x0_saturated", 32'(mx[0]), 32'd0);
      probe("left_saturated_0_11", 0, 11, C_OUT);

      repeat (40) begin
         send_move(0, 1);
         tick();
      end
      chk("model_pin_y0_saturated", 32'(my[0]), 32'd52);
      probe("down_saturated_0_63", 0, 63, C_OUT);
      probe("down_saturated_above_bg", 0, 51, C_BG);

      reset_dut();
      repeat (10) begin
         send_move(1, 2);
         tick();
      end
      chk("model_pin_x1", 32'(mx[1]), 32'd40);
      probe("overlap_sprite0_fill_wins", 40, 15, C_FILL);
      probe("overlap_sprite0_outline_wins", 57, 15, C_OUT);

      send_move(3, 3);
      tick();
      probe("bad_id_no_change", 40, 15, C_FILL);

      reset_dut();
      move_valid = 1'b1;
      move_id    = 2'd0;
      move_dir   = 2'd3;
      frame_tick = 1'b1;
      step();
      move_valid = 1'b0;
      frame_tick = 1'b0;
      chk("same_cycle_still_pending", 32'(move_ready), 32'd0);
      probe("same_cycle_unchanged", 30, 11, C_OUT);
      tick();
      probe("same_cycle_next_tick_moves", 30, 11, C_BG);

      send_move(0, 3);
      chk("pending_before_reset", 32'(move_ready), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_clears_pending", 32'(move_ready), 32'd1);
      probe("reset_restores_position", 30, 11, C_OUT);
      tick();
      probe("reset_drops_pending_move", 30, 11, C_OUT);

`ifdef SPRITE_BLINK_EN
      reset_dut();
      repeat (16) tick();
      probe("blink_fill_off", 32, 13, C_BG);
      probe("blink_outline_on", 30, 11, C_OUT);
      probe("blink_other_sprite_fill", 62, 13, C_FILL);
      repeat (16) tick();
      probe("blink_fill_back", 32, 13, C_FILL);
`endif

      reset_dut();
      for (int c = 0; c < 4000; c++) begin
         x          = 7'($urandom_range(0, 127));
         y          = 6'($urandom_range(0, 63));
         move_valid = ($urandom_range(0, 1) == 1);
         move_id    = 2'($urandom_range(0, 3));
         move_dir   = 2'($urandom_range(0, 3));
         frame_tick = ($urandom_range(0, 3) == 0);
         reset      = ($urandom_range(0, 299) == 0);
         step();
      end
      reset      = 1'b0;
      move_valid = 1'b0;
      frame_tick = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_scene_renderer.md
# sprite_scene_renderer

Clocked, parametrised successor to the fixed-scene game screens. It renders NUM_SPRITES movable rectangular sprites, each with a 2-px outline and a solid fill, over a background on the 96x64 OLED pixel stream. Per-sprite positions are held in registers and updated by a move-command handshake. Updates are committed only on frame boundaries, so one frame never shows a half-moved sprite. It sits between the game FSM, which issues moves, and the OLED driver, which supplies x/y and consumes oled_data.

## Interface
- NUM_SPRITES, 2: sprite count, 1..4.
- SPR_W, 28: sprite width in px, 4..96.
- SPR_H, 12: sprite height in px, 4..64.
- STEP, 2: px moved per command, 1..15.
- INIT_X, 30: reset x of sprite 0. Sprite i resets to INIT_X + i*(SPR_W+2), clamped to SCREEN_W-SPR_W.
- INIT_Y, 11: reset y of all sprites, clamped to SCREEN_H-SPR_H.
- OUTLINE_COLOUR, 16'h0000: RGB565 outline colour.
- FILL_COLOUR, 16'h8204: RGB565 fill colour (brown).
- BG_COLOUR, 16'h5FFF: RGB565 background colour (sky blue).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at the start of each OLED frame.
- x  in  7  pixel column, 0..95.
- y  in  6  pixel row, 0..63.
- move_valid  in  1  move command present.
- move_id  in  2  target sprite index.
- move_dir  in  2  direction: 0 = up, 1 = down, 2 = left, 3 = right.
- move_ready  out  1  command can be accepted.
- oled_data  out  16  RGB565 pixel for the x/y sampled one cycle earlier.

## Operation
- Reset values:
  - oled_data = BG_COLOUR.
  - move_ready = 1.
  - pending = 0.
  - Positions as in INIT_X/INIT_Y.
  - frame_cnt = 0.
  - sel = 0.
- State per sprite: pos_x (7 bits) and pos_y (6 bits).
- Command path: a 1-deep holding register holding pending, p_id and p_dir.
  - move_ready = ~pending.
  - On a cycle with move_valid && move_ready: latch id and dir, set pending.
  - A move_id ≥ NUM_SPRITES is accepted and then discarded at commit; no position changes.
- Commit: on frame_tick with pending = 1, apply the move to sprite p_id, clear pending and set sel = p_id.
- Arithmetic: compute in 8 bits, then saturate.
  - Left: pos_x < STEP → 0, else pos_x − STEP.
  - Right: pos_x + STEP > SCREEN_W−SPR_W → SCREEN_W−SPR_W.
  - Up and down are handled the same way on y, against SCREEN_H−SPR_H.
- Simultaneous frame_tick and acceptance: the commit uses the old pending value, which is 0. The new command waits for the next frame_tick.
- Pixel classification for sprite i:
  - Inside: pos_x ≤ x < pos_x+SPR_W and pos_y ≤ y < pos_y+SPR_H.
  - Outline: inside, and within 2 px of any edge.
  - Fill: inside and not outline.
- Priority: the lowest index wins on overlap. Outline and fill of the winning sprite are both opaque.
- Coordinates x ≥ 96 or y ≥ 64 output BG_COLOUR.
- frame_cnt: 5-bit counter, increments on every frame_tick and wraps from 31 to 0.

## Timing
- oled_data is registered: the colour for the (x, y) at cycle n appears at cycle n+1. There is no further pipeline.
- Acceptance-to-visible latency: the move becomes visible one cycle after the first frame_tick strictly after the acceptance cycle.
- move_ready falls the cycle after acceptance and rises the cycle after commit.
- Reset asserted mid-frame or with a command pending: all state returns to reset values on the next edge. Any pending command is lost.
- frame_tick pulses one cycle apart are legal; each one commits at most one command.

## Configuration
- SPRITE_BLINK_EN defined: while frame_cnt[4] = 1, the fill pixels of sprite sel render as BG_COLOUR. The outline is unaffected. This gives 16 frames on and 16 frames off.
- SPRITE_BLINK_EN undefined: frame_cnt and sel are not used for rendering, and all sprites always render fully.

## Test plan
- Reset check with defaults: after reset, sample (x, y) pairs.
  - (30,11) → 16'h0000 (outline).
  - (32,13) → 16'h8204 (fill).
  - (0,0) → 16'h5FFF (background).
  - (95,63) → 16'h5FFF (background).
  - All with 1-cycle latency.
- Handshake: with no frame_tick, issue move id 0 right.
  - move_ready goes 0 for the cycles that follow.
  - A second valid command is held off.
  - After one frame_tick, pixel (30,11) reads BG_COLOUR and (32,11) reads OUTLINE_COLOUR.
- Saturation:
  - 20 left moves on sprite 0, committed one per frame → pos_x = 0, and (0,11) reads outline.
  - 40 down moves → pos_y = 52, and (0,63) reads outline.
- Overlap and priority: move sprite 1 left until it overlaps sprite 0. The overlap region shows sprite 0's colours.
- Simultaneous events and reset:
  - Acceptance in the same cycle as frame_tick → the position is unchanged until the next tick.
  - Reset asserted while pending = 1 → move_ready = 1 and positions are restored next cycle.
- With SPRITE_BLINK_EN: after 16 frame_ticks, the fill of sprite sel reads 16'h5FFF while its outline still reads 16'h0000. After 32 frame_ticks, the fill reads 16'h8204 again.
